eb1_dccm_arb: RTL and testbench

Arbitrates the single DCCM port between two requesters: the core LSU and the DMA slave. LSU has fixed priority. A per-DMA starvation counter forces a DMA grant after a bounded wait. Partial-word writes become a two-cycle read-modify-write (RMW) sequence. Sits between the LSU/DMA request logic and the DCCM macro wrapper's lo port.

---
 rtl/eb1_dccm_arb_pkg.sv | 33 +++
 rtl/eb1_dccm_byte_merge.sv | 21 ++
 rtl/eb1_dccm_arb.sv | 201 ++++++++++++++++++++
 tb/tb_eb1_dccm_arb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eb1_dccm_arb_pkg.sv
// Shared types for the DCCM port arbiter.
//   eb1_dccm_arb_req_pkt_t : request attributes captured for an RMW sequence
//   eb1_dccm_arb_state_t   : arbiter FSM states
//   OWN_LSU / OWN_DMA      : 1-bit owner tag for in-flight reads
//   word_align()           : clears byte-offset bits of a DCCM address
package eb1_dccm_arb_pkg;

    localparam int unsigned ARB_ADDR_W = 16;
    localparam int unsigned ARB_DATA_W = 32;
    localparam int unsigned ARB_BE_W   = ARB_DATA_W / 8;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_BE_W-1:0]   wbe;
    } eb1_dccm_arb_req_pkt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } eb1_dccm_arb_state_t;

    localparam logic OWN_LSU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // DCCM is word-addressed; bits [1:0] never reach the macro.
    function automatic logic [ARB_ADDR_W-1:0] word_align(input logic [ARB_ADDR_W-1:0] addr);
        return {addr[ARB_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/eb1_dccm_byte_merge.sv
// Per-byte select between new and old data (shared with the ECC scrub path).
//   new_data : bytes taken where be[i] is set
//   old_data : bytes taken where be[i] is clear
//   be       : byte enables, one per byte
//   merged_c : combinational merged word
module eb1_dccm_byte_merge #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   new_data,
    input  logic [DATA_W-1:0]   old_data,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   merged_c
);

    localparam int unsigned BE_W = DATA_W / 8;

    for (genvar i = 0; i < BE_W; i++) begin : g_byte
        assign merged_c[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end

endmodule

// File: rtl/eb1_dccm_arb.sv
// DCCM lo-port arbiter between the LSU and the DMA slave.
//   LSU has fixed priority; a starvation counter forces a DMA grant once a
//   pending DMA request has been refused DMA_MAX_WAIT times. Partial writes
//   run as a read, merge-and-write, turnaround-bubble sequence.
// Ports:
//   clk, rst                         : clock, async active-high reset
//   lsu_* / dma_*                    : requester channels (req/gnt handshake,
//                                      read data returned one cycle after gnt)
//   dccm_rden/wren, *_addr_lo, data  : DCCM macro lo-port (read data lags rden by 1)
//   arb_busy                         : FSM is inside an RMW sequence
// The RMW packet type is sized by the package widths, so DCCM_BITS and DATA_W
// are expected to stay at ARB_ADDR_W / ARB_DATA_W.
module eb1_dccm_arb
    import eb1_dccm_arb_pkg::*;
#(
    parameter int unsigned DCCM_BITS    = ARB_ADDR_W,
    parameter int unsigned DATA_W       = ARB_DATA_W,
    parameter int unsigned DMA_MAX_WAIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   lsu_req,
    input  logic                   lsu_we,
    input  logic [DCCM_BITS-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]      lsu_wdata,
    input  logic [DATA_W/8-1:0]    lsu_wbe,
    output logic                   lsu_gnt,
    output logic                   lsu_rvalid,
    output logic [DATA_W-1:0]      lsu_rdata,

    input  logic                   dma_req,
    input  logic                   dma_we,
    input  logic [DCCM_BITS-1:0]   dma_addr,
    input  logic [DATA_W-1:0]      dma_wdata,
    input  logic [DATA_W/8-1:0]    dma_wbe,
    output logic                   dma_gnt,
    output logic                   dma_rvalid,
    output logic [DATA_W-1:0]      dma_rdata,

    output logic                   dccm_rden,
    output logic                   dccm_wren,
    output logic [DCCM_BITS-1:0]   dccm_rd_addr_lo,
    output logic [DCCM_BITS-1:0]   dccm_wr_addr_lo,
    output logic [DATA_W-1:0]      dccm_wr_data_lo,
    input  logic [DATA_W-1:0]      dccm_rd_data_lo,

    output logic                   arb_busy
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] MAX_WAIT = CNT_W'(DMA_MAX_WAIT);

    eb1_dccm_arb_state_t   state, state_nxt;
    eb1_dccm_arb_req_pkt_t lsu_pkt, dma_pkt, win_pkt, rmw_pkt;

    logic [CNT_W-1:0]  starve_cnt;
    logic              rd_pending;
    logic              rd_owner;
    logic              rd_issue;
    logic              rmw_start;
    logic [DATA_W-1:0] lsu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic [DATA_W-1:0] merged;

    // Pack requester attributes into the shared packet shape.
    assign lsu_pkt = '{we:    lsu_we,
                       addr:  ARB_ADDR_W'(lsu_addr),
                       wdata: ARB_DATA_W'(lsu_wdata),
                       wbe:   ARB_BE_W'(lsu_wbe)};
    assign dma_pkt = '{we:    dma_we,
                       addr:  ARB_ADDR_W'(dma_addr),
                       wdata: ARB_DATA_W'(dma_wdata),
                       wbe:   ARB_BE_W'(dma_wbe)};
    assign win_pkt = dma_gnt ? dma_pkt : lsu_pkt;

    eb1_dccm_byte_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .new_data (DATA_W'(rmw_pkt.wdata)),
        .old_data (dccm_rd_data_lo),
        .be       (BE_W'(rmw_pkt.wbe)),
        .merged_c (merged)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, next state and DCCM port drive.
    always_comb begin
        state_nxt       = state;
        lsu_gnt         = 1'b0;
        dma_gnt         = 1'b0;
        dccm_rden       = 1'b0;
        dccm_wren       = 1'b0;
        dccm_rd_addr_lo = '0;
        dccm_wr_addr_lo = '0;
        dccm_wr_data_lo = '0;
        rd_issue        = 1'b0;
        rmw_start       = 1'b0;

        // Grants only in IDLE; a starved DMA overrides LSU priority.
        if (!rst && (state == IDLE)) begin
            if (dma_req && (starve_cnt == MAX_WAIT)) begin
                dma_gnt = 1'b1;
            end else if (lsu_req) begin
                lsu_gnt = 1'b1;
            end else if (dma_req) begin
                dma_gnt = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (lsu_gnt || dma_gnt) begin
                    if (!win_pkt.we) begin
                        dccm_rden       = 1'b1;
                        dccm_rd_addr_lo = DCCM_BITS'(word_align(win_pkt.addr));
                        rd_issue        = 1'b1;
                    end else if (&win_pkt.wbe) begin
                        dccm_wren       = 1'b1;
                        dccm_wr_addr_lo = DCCM_BITS'(word_align(win_pkt.addr));
                        dccm_wr_data_lo = DATA_W'(win_pkt.wdata);
                    end else if (|win_pkt.wbe) begin
                        // Partial write: fetch the old word first.
                        dccm_rden       = 1'b1;
                        dccm_rd_addr_lo = DCCM_BITS'(word_align(win_pkt.addr));
                        rmw_start       = 1'b1;
                        state_nxt       = RMW_RD;
                    end
                    // wbe == 0 write: accepted, no DCCM access.
                end
            end
            RMW_RD: begin
                dccm_wren       = rmw_pkt.we;
                dccm_wr_addr_lo = DCCM_BITS'(word_align(rmw_pkt.addr));
                dccm_wr_data_lo = merged;
                state_nxt       = RMW_WR;
            end
            RMW_WR: begin
                // Turnaround bubble after the merged write.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // RMW capture, read-owner tracking and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rmw_pkt    <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= OWN_LSU;
            starve_cnt <= '0;
        end else begin
            if (rmw_start) begin
                rmw_pkt <= win_pkt;
            end
            rd_pending <= rd_issue;
            if (rd_issue) begin
                rd_owner <= dma_gnt ? OWN_DMA : OWN_LSU;
            end
            if (dma_gnt || !dma_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != MAX_WAIT) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // Read data is steered from the macro in the return cycle and held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (lsu_rvalid) begin
                lsu_rdata_q <= dccm_rd_data_lo;
            end
            if (dma_rvalid) begin
                dma_rdata_q <= dccm_rd_data_lo;
            end
        end
    end

    assign lsu_rvalid = rd_pending && (rd_owner == OWN_LSU);
    assign dma_rvalid = rd_pending && (rd_owner == OWN_DMA);
    assign lsu_rdata  = lsu_rvalid ? dccm_rd_data_lo : lsu_rdata_q;
    assign dma_rdata  = dma_rvalid ? dccm_rd_data_lo : dma_rdata_q;
    assign arb_busy   = (state != IDLE);

endmodule

// File: tb/tb_eb1_dccm_arb.sv
// Scoreboard bench for eb1_dccm_arb: stimulus pushes expected read data and
// DCCM writes into queues; a negedge monitor pops and compares them.
module tb_eb1_dccm_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
    logic [15:0] lsu_addr;
    logic [31:0] lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wbe;
    logic        dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [15:0] dma_addr;
    logic [31:0] dma_wdata, dma_rdata;
    logic [3:0]  dma_wbe;
    logic        dccm_rden, dccm_wren, arb_busy;
    logic [15:0] dccm_rd_addr_lo, dccm_wr_addr_lo;
    logic [31:0] dccm_wr_data_lo, dccm_rd_data_lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_lsu[$];
    logic [31:0] exp_dma[$];
    logic [47:0] exp_wr[$];

    logic [31:0] mem [0:1023];
    logic [31:0] rd_q;

    always #5 clk = ~clk;

    eb1_dccm_arb #(.DCCM_BITS(16), .DATA_W(32), .DMA_MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wbe(lsu_wbe), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_wbe(dma_wbe), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .dccm_rden(dccm_rden), .dccm_wren(dccm_wren),
        .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_wr_addr_lo(dccm_wr_addr_lo),
        .dccm_wr_data_lo(dccm_wr_data_lo), .dccm_rd_data_lo(dccm_rd_data_lo),
        .arb_busy(arb_busy)
    );

    // DCCM macro model: one-cycle read latency, write on the clock edge.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        mem[16'h0040 >> 2] <= 32'hDEAD_BEEF;
        mem[16'h0080 >> 2] <= 32'h0BAD_F00D;
        mem[16'h00C0 >> 2] <= 32'h0C0F_FEE0;
        mem[16'h0200 >> 2] <= 32'h1122_3344;
        mem[16'h0240 >> 2] <= 32'h5566_7788;
    end
    always @(posedge clk) begin
        if (dccm_rden) rd_q <= mem[dccm_rd_addr_lo[11:2]];
        if (dccm_wren) mem[dccm_wr_addr_lo[11:2]] <= dccm_wr_data_lo;
    end
    assign dccm_rd_data_lo = rd_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected output 0x%0h with nothing expected", name, act);
    endtask

    // Monitor: compare every presented response against the scoreboard.
    always @(negedge clk) begin
        if (lsu_rvalid) begin
            if (exp_lsu.size() == 0) unexpected("lsu_rvalid", 64'(lsu_rdata));
            else check("lsu_rdata", 64'(lsu_rdata), 64'(exp_lsu.pop_front()));
        end
        if (dma_rvalid) begin
            if (exp_dma.size() == 0) unexpected("dma_rvalid", 64'(dma_rdata));
            else check("dma_rdata", 64'(dma_rdata), 64'(exp_dma.pop_front()));
        end
        if (dccm_wren) begin
            if (exp_wr.size() == 0) unexpected("dccm_wren", 64'({dccm_wr_addr_lo, dccm_wr_data_lo}));
            else check("dccm_write", 64'({dccm_wr_addr_lo, dccm_wr_data_lo}), 64'(exp_wr.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wbe = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_wbe = '0;
    endtask

    task automatic lsu_rd(input logic [15:0] a);
        lsu_req = 1; lsu_we = 0; lsu_addr = a; lsu_wbe = 4'hF;
    endtask

    task automatic dma_rd(input logic [15:0] a);
        dma_req = 1; dma_we = 0; dma_addr = a; dma_wbe = 4'hF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lsu_idx;
        logic dma_pend;
        logic exp_dma_win;

        idle_inputs();
        rst = 1;
        lsu_rd(16'h0040);
        dma_rd(16'h0080);
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset state with both requesters asserting.
        check("rst_lsu_gnt", 64'(lsu_gnt), 64'd0);
        check("rst_dma_gnt", 64'(dma_gnt), 64'd0);
        check("rst_rden", 64'(dccm_rden), 64'd0);
        check("rst_wren", 64'(dccm_wren), 64'd0);
        check("rst_busy", 64'(arb_busy), 64'd0);
        check("rst_rd_addr", 64'(dccm_rd_addr_lo), 64'd0);
        check("rst_wr_addr", 64'(dccm_wr_addr_lo), 64'd0);
        check("rst_wr_data", 64'(dccm_wr_data_lo), 64'd0);
        check("rst_lsu_rdata", 64'(lsu_rdata), 64'd0);
        check("rst_dma_rdata", 64'(dma_rdata), 64'd0);

        step(); rst = 0; idle_inputs();
        step();

        // LSU read of 0x0040.
        lsu_rd(16'h0040);
        exp_lsu.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        check("t1_lsu_gnt", 64'(lsu_gnt), 64'd1);
        check("t1_dma_gnt", 64'(dma_gnt), 64'd0);
        check("t1_rden", 64'(dccm_rden), 64'd1);
        check("t1_rd_addr", 64'(dccm_rd_addr_lo), 64'h0040);
        step(); idle_inputs();
        step();
        @(negedge clk);
        check("t1_rdata_hold", 64'(lsu_rdata), 64'hDEAD_BEEF);
        check("t1_rvalid_low", 64'(lsu_rvalid), 64'd0);

        // Simultaneous requests, then back-to-back DMA read; unaligned LSU address.
        step();
        lsu_rd(16'h0043);
        dma_rd(16'h0080);
        exp_lsu.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        check("t2_lsu_gnt", 64'(lsu_gnt), 64'd1);
        check("t2_dma_gnt", 64'(dma_gnt), 64'd0);
        check("t2_rd_addr_aligned", 64'(dccm_rd_addr_lo), 64'h0040);
        step(); lsu_req = 0;
        exp_dma.push_back(32'h0BAD_F00D);
        @(negedge clk);
        check("t2_dma_gnt2", 64'(dma_gnt), 64'd1);
        check("t2_rd_addr2", 64'(dccm_rd_addr_lo), 64'h0080);
        step(); idle_inputs();

        // Starvation: LSU streams reads for 10 cycles while DMA waits.
        lsu_idx  = 0;
        dma_pend = 1;
        for (int c = 1; c <= 10; c++) begin
            lsu_rd(16'(16'h0100 + 4 * lsu_idx));
            dma_req = dma_pend; dma_we = 0; dma_addr = 16'h00C0; dma_wbe = 4'hF;
            exp_dma_win = (c == 9);
            if (exp_dma_win) exp_dma.push_back(32'h0C0F_FEE0);
            else exp_lsu.push_back(32'hA500_0000 | 32'((16'h0100 >> 2) + lsu_idx));
            @(negedge clk);
            check($sformatf("t3_c%0d_lsu_gnt", c), 64'(lsu_gnt), 64'(!exp_dma_win));
            check($sformatf("t3_c%0d_dma_gnt", c), 64'(dma_gnt), 64'(exp_dma_win));
            if (exp_dma_win) dma_pend = 0;
            else lsu_idx++;
            step();
        end
        idle_inputs();

        // Counter must be cleared again: LSU wins a fresh collision.
        lsu_rd(16'h0040);
        dma_rd(16'h0080);
        exp_lsu.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        check("t3_after_lsu_gnt", 64'(lsu_gnt), 64'd1);
        check("t3_after_dma_gnt", 64'(dma_gnt), 64'd0);
        step(); lsu_req = 0;
        exp_dma.push_back(32'h0BAD_F00D);
        @(negedge clk);
        check("t3_after_dma_gnt2", 64'(dma_gnt), 64'd1);
        step(); idle_inputs();

        // DMA partial write: byte 1 of 0x11223344 <- 0xAB.
        dma_req = 1; dma_we = 1; dma_addr = 16'h0200; dma_wdata = 32'h0000_AB00; dma_wbe = 4'b0010;
        exp_wr.push_back({16'h0200, 32'h1122_AB44});
        @(negedge clk);
        check("t4_dma_gnt", 64'(dma_gnt), 64'd1);
        check("t4_rden", 64'(dccm_rden), 64'd1);
        check("t4_rd_addr", 64'(dccm_rd_addr_lo), 64'h0200);
        check("t4_wren_T", 64'(dccm_wren), 64'd0);
        step(); idle_inputs(); lsu_rd(16'h0200);
        @(negedge clk);
        check("t4_T1_lsu_gnt", 64'(lsu_gnt), 64'd0);
        check("t4_T1_busy", 64'(arb_busy), 64'd1);
        check("t4_T1_wren", 64'(dccm_wren), 64'd1);
        check("t4_T1_rden", 64'(dccm_rden), 64'd0);
        step();
        @(negedge clk);
        check("t4_T2_lsu_gnt", 64'(lsu_gnt), 64'd0);
        check("t4_T2_busy", 64'(arb_busy), 64'd1);
        check("t4_T2_wren", 64'(dccm_wren), 64'd0);
        check("t4_T2_rden", 64'(dccm_rden), 64'd0);
        step();
        exp_lsu.push_back(32'h1122_AB44);
        @(negedge clk);
        check("t4_T3_lsu_gnt", 64'(lsu_gnt), 64'd1);
        check("t4_T3_busy", 64'(arb_busy), 64'd0);
        step(); idle_inputs();

        // LSU full write then readback.
        lsu_req = 1; lsu_we = 1; lsu_addr = 16'h0300; lsu_wdata = 32'hCAFE_F00D; lsu_wbe = 4'hF;
        exp_wr.push_back({16'h0300, 32'hCAFE_F00D});
        @(negedge clk);
        check("t5_lsu_gnt", 64'(lsu_gnt), 64'd1);
        check("t5_rden", 64'(dccm_rden), 64'd0);
        check("t5_busy", 64'(arb_busy), 64'd0);
        step(); idle_inputs(); lsu_rd(16'h0300);
        exp_lsu.push_back(32'hCAFE_F00D);
        @(negedge clk);
        check("t5_rb_gnt", 64'(lsu_gnt), 64'd1);
        step(); idle_inputs();

        // wbe == 0 write is a granted no-op.
        dma_req = 1; dma_we = 1; dma_addr = 16'h0080; dma_wdata = 32'hFFFF_FFFF; dma_wbe = 4'h0;
        @(negedge clk);
        check("t6_dma_gnt", 64'(dma_gnt), 64'd1);
        check("t6_rden", 64'(dccm_rden), 64'd0);
        check("t6_wren", 64'(dccm_wren), 64'd0);
        step(); idle_inputs();
        @(negedge clk);
        check("t6_busy", 64'(arb_busy), 64'd0);
        step(); dma_rd(16'h0080);
        exp_dma.push_back(32'h0BAD_F00D);
        @(negedge clk);
        check("t6_rb_gnt", 64'(dma_gnt), 64'd1);
        step(); idle_inputs();

        // Reset in the RMW_RD cycle aborts the merged write.
        lsu_req = 1; lsu_we = 1; lsu_addr = 16'h0240; lsu_wdata = 32'h0000_00FF; lsu_wbe = 4'b0001;
        @(negedge clk);
        check("t7_lsu_gnt", 64'(lsu_gnt), 64'd1);
        check("t7_rden", 64'(dccm_rden), 64'd1);
        step(); idle_inputs(); rst = 1; lsu_rd(16'h0040); dma_rd(16'h0080);
        @(negedge clk);
        check("t7_rst_wren", 64'(dccm_wren), 64'd0);
        check("t7_rst_busy", 64'(arb_busy), 64'd0);
        check("t7_rst_rden", 64'(dccm_rden), 64'd0);
        check("t7_rst_lsu_gnt", 64'(lsu_gnt), 64'd0);
        check("t7_rst_dma_gnt", 64'(dma_gnt), 64'd0);
        check("t7_rst_lsu_rdata", 64'(lsu_rdata), 64'd0);
        check("t7_rst_dma_rdata", 64'(dma_rdata), 64'd0);
        step(); rst = 0; idle_inputs(); lsu_rd(16'h0240);
        exp_lsu.push_back(32'h5566_7788);
        @(negedge clk);
        check("t7_post_lsu_gnt", 64'(lsu_gnt), 64'd1);
        check("t7_post_rden", 64'(dccm_rden), 64'd1);
        step(); idle_inputs();

        // Drain and confirm every expected response was seen.
        repeat (3) step();
        check("drain_lsu", 64'(exp_lsu.size()), 64'd0);
        check("drain_dma", 64'(exp_dma.size()), 64'd0);
        check("drain_wr", 64'(exp_wr.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
